// File: rtl/pipelined_bitwise_shift_right.sv
// Valid/ready right shifter with one register stage per shift-amount bit.
// Stage k conditionally shifts by 2**k with a zero or sign fill captured at stage 0.
module pipelined_bitwise_shift_right #(
    parameter int N = 8,
    parameter int O = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [O-1:0] in_b,
    input  logic         in_arith,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_c
);

    logic [O-1:0] en;
    logic [O-1:0] vAll;
    logic         enChain;

    // A stage may load when it is empty or the stage after it is moving, so bubbles collapse.
    always_comb begin
        enChain = out_ready;
        en      = '0;
        for (int k = O - 1; k >= 0; k--) begin
            enChain = ~vAll[k] | enChain;
            en[k]   = enChain;
        end
    end

    for (genvar k = 0; k < O; k++) begin : stg
        localparam int SH = 1 << k;

        logic           srcV;
        logic           srcFill;
        logic [N-1:0]   srcData;
        logic [O-k-1:0] srcAmt;
        logic [N-1:0]   dataD;
        logic           validQ;
        logic [N-1:0]   dataQ;

        if (k == 0) begin : head
            assign srcV    = in_valid & en[0];
            assign srcData = in_a;
            assign srcAmt  = in_b;
            assign srcFill = in_arith & in_a[N-1];
        end else begin : body
            assign srcV    = stg[k-1].validQ;
            assign srcData = stg[k-1].dataQ;
            assign srcAmt  = stg[k-1].carry.amtQ;
            assign srcFill = stg[k-1].carry.fillQ;
        end

        // Bit 0 of the remaining amount always belongs to this stage; the rest moves on.
        assign dataD = srcAmt[0] ? {{SH{srcFill}}, srcData[N-1:SH]} : srcData;

        always_ff @(posedge clk) begin
            if (rst) begin
                validQ <= 1'b0;
                dataQ  <= '0;
            end else if (en[k]) begin
                validQ <= srcV;
                dataQ  <= dataD;
            end
        end

        if (k < O - 1) begin : carry
            logic [O-k-2:0] amtQ;
            logic           fillQ;

            always_ff @(posedge clk) begin
                if (rst) begin
                    amtQ  <= '0;
                    fillQ <= 1'b0;
                end else if (en[k]) begin
                    amtQ  <= srcAmt[O-k-1:1];
                    fillQ <= srcFill;
                end
            end
        end

        assign vAll[k] = validQ;
    end

    assign in_ready  = en[0];
    assign out_valid = vAll[O-1];
    assign out_c     = stg[O-1].dataQ;

endmodule

// File: tb/tb_pipelined_bitwise_shift_right.sv
// Scoreboard bench for pipelined_bitwise_shift_right (N=8): stimulus pushes expected results,
// a negedge monitor pops and compares them as the shifter emits.
module tb_pipelined_bitwise_shift_right;
    localparam int N = 8;
    localparam int O = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [O-1:0] in_b;
    logic         in_arith;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_c;

    typedef struct {
        logic [N-1:0] data;
        int           acceptCyc;
        bit           latChk;
        string        name;
    } expT;

    expT          sb[$];
    int           cyc       = 0;
    int           total     = 0;
    int           bad       = 0;
    int           popCount  = 0;
    bit           prevStall = 1'b0;
    logic [N-1:0] prevC     = '0;

    pipelined_bitwise_shift_right #(.N(N), .O(O)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_arith  (in_arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] refShift(input logic [N-1:0] a, input logic [O-1:0] b,
                                              input logic arith);
        if (arith) return $signed(a) >>> b;
        return a >> b;
    endfunction

    // Drive one operation and wait (bounded) for the handshake; expected value is queued on accept.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [O-1:0] b, input logic arith,
                                 input logic [N-1:0] exp, input bit push, input bit latChk,
                                 input string name);
        bit accepted = 1'b0;
        expT e;
        in_a     = a;
        in_b     = b;
        in_arith = arith;
        in_valid = 1'b1;
        for (int w = 0; w < 50 && !accepted; w++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                if (push) begin
                    e.data      = exp;
                    e.acceptCyc = cyc;
                    e.latChk    = latChk;
                    e.name      = name;
                    sb.push_back(e);
                end
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        if (!accepted) begin
            total++;
            bad++;
            $display("[TB] FAIL %s accept: got no in_ready expected handshake", name);
        end
    endtask

    task automatic checkOutput(input expT e);
        check({e.name, " data"}, out_c, e.data);
        if (e.latChk) check({e.name, " latency"}, cyc - e.acceptCyc, O);
    endtask

    // Monitor: compares every emitted result and guards output stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                check("stall valid held", out_valid, 1);
                check("stall data held", out_c, prevC);
            end
            if (out_valid && out_ready) begin
                popCount++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected output: got %0h expected none", out_c);
                end else begin
                    checkOutput(sb.pop_front());
                end
            end
            prevStall = out_valid && !out_ready;
            prevC     = out_c;
        end
    end

    initial begin
        logic [N-1:0] ra;
        logic [O-1:0] rb;
        logic         rar;
        int           base;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_arith = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("reset out_valid", out_valid, 0);
        check("reset out_c", out_c, 0);
        check("reset in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus(8'h80, 3, 0, 8'h10, 1, 1, "logical 80>>3");
        repeat (5) @(posedge clk);
        #1;

        applyStimulus(8'h80, 3, 1, 8'hF0, 1, 1, "arith 80>>3");
        applyStimulus(8'h70, 3, 1, 8'h0E, 1, 1, "arith 70>>3");
        applyStimulus(8'hFF, 7, 1, 8'hFF, 1, 1, "arith FF>>7");
        applyStimulus(8'hFF, 7, 0, 8'h01, 1, 1, "logical FF>>7");
        applyStimulus(8'h7F, 7, 1, 8'h00, 1, 1, "arith 7F>>7");
        applyStimulus(8'hA5, 0, 0, 8'hA5, 1, 1, "logical A5>>0");
        applyStimulus(8'hA5, 0, 1, 8'hA5, 1, 1, "arith A5>>0");
        repeat (5) @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            ra  = N'($urandom_range(0, 255));
            rb  = O'($urandom_range(0, N - 1));
            rar = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rar, refShift(ra, rb, rar), 1, 1, $sformatf("stream%0d", i));
        end
        repeat (5) @(posedge clk);
        #1;

        out_ready = 1'b0;
        applyStimulus(8'h81, 1, 1, 8'hC0, 1, 0, "stall op1");
        applyStimulus(8'h81, 1, 0, 8'h40, 1, 0, "stall op2");
        applyStimulus(8'h3C, 2, 0, 8'h0F, 1, 0, "stall op3");
        check("full in_ready", in_ready, 0);
        check("full out_valid", out_valid, 1);
        in_a = 8'hF0; in_b = 4; in_arith = 1'b1; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("held full in_ready", in_ready, 0);
        out_ready = 1'b1;
        #1;
        check("ready same cycle", in_ready, 1);
        applyStimulus(8'hF0, 4, 1, 8'hFF, 1, 0, "stall op4");
        applyStimulus(8'h0F, 4, 0, 8'h00, 1, 0, "stall op5");
        repeat (6) @(posedge clk);
        #1;

        out_ready = 1'b0;
        applyStimulus(8'h96, 2, 0, 8'h25, 1, 0, "bubble A");
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(8'h96, 2, 1, 8'hE5, 1, 0, "bubble B");
        @(posedge clk);
        #1;
        check("bubble out_valid", out_valid, 1);
        check("bubble head", out_c, 8'h25);
        check("bubble in_ready", in_ready, 1);
        base = popCount;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("bubble consecutive pops", popCount - base, 2);

        applyStimulus(8'h55, 1, 0, 8'h2A, 0, 0, "flushed op1");
        applyStimulus(8'hAA, 1, 1, 8'hD5, 0, 0, "flushed op2");
        rst = 1'b1; in_valid = 1'b1; in_a = 8'hFF; in_b = 1; in_arith = 1'b1;
        @(posedge clk);
        #1;
        check("mid reset out_valid", out_valid, 0);
        check("mid reset out_c", out_c, 0);
        check("mid reset in_ready", in_ready, 1);
        rst = 1'b0; in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("no stale after reset", out_valid, 0);

        for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge clk);
        check("scoreboard drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
